// File: rtl/ysyx_24090003_dmem_resp_pkg.sv
// Shared definitions for the ysyx_24090003 data-memory responder.
//   - store width codes (match the store funct3 encoding)
//   - responder FSM state encoding
//   - latency counter width
//   - helpers that place right-aligned store data into byte lanes
package ysyx_24090003_dmem_resp_pkg;

  localparam logic [2:0] MemWByte = 3'b000;
  localparam logic [2:0] MemWHalf = 3'b001;
  localparam logic [2:0] MemWWord = 3'b010;

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    DmemIdle = 2'b00,
    DmemWait = 2'b01,
    DmemResp = 2'b10
  } dmem_state_e;

  // Byte enables for a store of the given width at the given byte offset.
  function automatic logic [3:0] lane_be(input logic [2:0] width, input logic [1:0] ofs);
    logic [3:0] be;
    be = 4'b0000;
    unique case (width)
      MemWByte: be = 4'b0001 << ofs;
      MemWHalf: be = ofs[1] ? 4'b1100 : 4'b0011;
      MemWWord: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the low bytes across the word so every candidate lane carries them.
  function automatic logic [31:0] lane_data(input logic [2:0] width, input logic [31:0] data);
    logic [31:0] d;
    unique case (width)
      MemWByte: d = {4{data[7:0]}};
      MemWHalf: d = {2{data[15:0]}};
      default:  d = data;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ysyx_24090003_dmem_array.sv
// Word-organised storage for the data-memory responder.
//   i_clk    : clock
//   i_idx    : word index for both read and write
//   i_we     : write strobe, i_be selects the byte lanes written
//   i_wdata  : lane-positioned write data
//   i_re     : read strobe; o_rdata is registered and holds between reads
// Contents and the read register are not reset.
module ysyx_24090003_dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IdxW = $clog2(DEPTH_WORDS)
) (
  input  logic            i_clk,
  input  logic [IdxW-1:0] i_idx,
  input  logic            i_we,
  input  logic [3:0]      i_be,
  input  logic [31:0]     i_wdata,
  input  logic            i_re,
  output logic [31:0]     o_rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) mem_q[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) o_rdata <= mem_q[i_idx];
  end

endmodule

// File: rtl/ysyx_24090003_dmem_resp.sv
// Data-memory responder: target end of the core's o_mem_* load/store port.
// One request at a time; response after LATENCY cycles.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_mem_en         : request valid (accepted when o_mem_ready is high)
//   i_mem_we         : 1 = store, 0 = load
//   i_mem_addr       : byte address
//   i_mem_wdata      : right-aligned store data
//   i_mem_wmask      : width code (000 byte, 001 half, 010 word)
//   o_mem_ready      : can accept a request this cycle
//   o_mem_rvalid     : response valid
//   i_mem_rready     : initiator accepts the response
//   o_mem_rdata      : aligned word for good loads, 0 otherwise
//   o_mem_err        : response is an error
module ysyx_24090003_dmem_resp
  import ysyx_24090003_dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_en,
  input  logic        i_mem_we,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [2:0]  i_mem_wmask,
  output logic        o_mem_ready,
  output logic        o_mem_rvalid,
  input  logic        i_mem_rready,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_err
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 2);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("LATENCY must be in 1..15");
  end
  if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 || DEPTH_WORDS < 2) begin : g_bad_depth
    $error("DEPTH_WORDS must be a power of two, at least 2");
  end

  dmem_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        accept;
  logic [29:0] word_off;
  logic        below, over, misalign, bad_code, req_err;
  logic        arr_we, arr_re;
  logic [31:0] arr_rdata;

  // Response bookkeeping captured at accept, and the last presented response
  // which is shown whenever no response is pending.
  logic        load_ok_q, err_q;
  logic [31:0] hold_rdata_q;
  logic        hold_err_q;

  assign o_mem_ready  = (state_q == DmemIdle);
  assign o_mem_rvalid = (state_q == DmemResp);
  assign accept       = i_mem_en && o_mem_ready;

  // BASE_ADDR is word aligned, so the word offset is a difference of word addresses.
  assign word_off = i_mem_addr[31:2] - BASE_ADDR[31:2];
  assign below    = i_mem_addr < BASE_ADDR;
  assign over     = {2'b00, word_off} >= DEPTH_WORDS;

  always_comb begin
    misalign = 1'b0;
    if (i_mem_wmask == MemWHalf) misalign = i_mem_addr[0];
    if (i_mem_wmask == MemWWord) misalign = (i_mem_addr[1:0] != 2'b00);
  end

  // Loads only care about alignment; an unknown width code is a store error.
  assign bad_code = i_mem_we && (i_mem_wmask != MemWByte) && (i_mem_wmask != MemWHalf) &&
                    (i_mem_wmask != MemWWord);
  assign req_err  = below || over || misalign || bad_code;

  assign arr_we = accept && i_mem_we && !req_err;
  assign arr_re = accept && !i_mem_we && !req_err;

  ysyx_24090003_dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .i_clk  (i_clk),
    .i_idx  (word_off[IdxW-1:0]),
    .i_we   (arr_we),
    .i_be   (lane_be(i_mem_wmask, i_mem_addr[1:0])),
    .i_wdata(lane_data(i_mem_wmask, i_mem_wdata)),
    .i_re   (arr_re),
    .o_rdata(arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DmemIdle: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = DmemResp;
          end else begin
            state_d = DmemWait;
            cnt_d   = CntInit;
          end
        end
      end
      DmemWait: begin
        if (cnt_q == '0) state_d = DmemResp;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      DmemResp: begin
        if (i_mem_rready) state_d = DmemIdle;
      end
      default: state_d = DmemIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= DmemIdle;
      cnt_q        <= '0;
      load_ok_q    <= 1'b0;
      err_q        <= 1'b0;
      hold_rdata_q <= '0;
      hold_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        load_ok_q <= !i_mem_we && !req_err;
        err_q     <= req_err;
      end
      if (o_mem_rvalid && i_mem_rready) begin
        hold_rdata_q <= o_mem_rdata;
        hold_err_q   <= o_mem_err;
      end
    end
  end

  // The array read register updates at accept; muxing with the held copy keeps
  // the outputs unchanged until the response is actually presented.
  assign o_mem_rdata = o_mem_rvalid ? (load_ok_q ? arr_rdata : 32'h0) : hold_rdata_q;
  assign o_mem_err   = o_mem_rvalid ? err_q : hold_err_q;

endmodule

// File: tb/tb_ysyx_24090003_dmem_resp.sv
module tb_ysyx_24090003_dmem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: LATENCY=1, 1: LATENCY=4, 2: LATENCY=8.
  logic [2:0]  rst_n, en, we, rready;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [2:0]  wmask [3];
  logic [2:0]  ready, rvalid, err;
  logic [31:0] rdata [3];

  ysyx_24090003_dmem_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) u_l1 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_mem_en(en[0]), .i_mem_we(we[0]),
    .i_mem_addr(addr[0]), .i_mem_wdata(wdata[0]), .i_mem_wmask(wmask[0]),
    .o_mem_ready(ready[0]), .o_mem_rvalid(rvalid[0]), .i_mem_rready(rready[0]),
    .o_mem_rdata(rdata[0]), .o_mem_err(err[0])
  );
  ysyx_24090003_dmem_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(4)) u_l4 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_mem_en(en[1]), .i_mem_we(we[1]),
    .i_mem_addr(addr[1]), .i_mem_wdata(wdata[1]), .i_mem_wmask(wmask[1]),
    .o_mem_ready(ready[1]), .o_mem_rvalid(rvalid[1]), .i_mem_rready(rready[1]),
    .o_mem_rdata(rdata[1]), .o_mem_err(err[1])
  );
  ysyx_24090003_dmem_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(8)) u_l8 (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_mem_en(en[2]), .i_mem_we(we[2]),
    .i_mem_addr(addr[2]), .i_mem_wdata(wdata[2]), .i_mem_wmask(wmask[2]),
    .o_mem_ready(ready[2]), .o_mem_rvalid(rvalid[2]), .i_mem_rready(rready[2]),
    .o_mem_rdata(rdata[2]), .o_mem_err(err[2])
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Wait for rvalid, counting cycles since the accept edge and cycles with ready low.
  task automatic wait_resp(input int k, output logic [31:0] rd, output logic er,
                           output int lat, output int rl);
    lat = 0;
    rl  = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (!ready[k]) rl++;
      if (rvalid[k]) break;
    end
    rd = rdata[k];
    er = err[k];
  endtask

  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] m, output logic [31:0] rd, output logic er,
                     output int lat, output int rl);
    @(negedge clk);
    en[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; wmask[k] = m; rready[k] = 1'b1;
    @(posedge clk);
    #1 en[k] = 1'b0;
    wait_resp(k, rd, er, lat, rl);
    @(negedge clk);
    if (!ready[k]) rl++;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  m;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vecs [22];

  initial begin
    logic [31:0] rd, a, d;
    logic        er;
    int          lat, rl, bad_cycles;

    vecs[0]  = '{1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0000, 32'h0,         3'b010, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0002, 32'h0000_0011, 3'b000, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0000, 32'h0000_2233, 3'b001, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 32'h8000_0000, 32'h0,         3'b010, 32'hDE11_2233, 1'b0};
    vecs[5]  = '{1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 3'b010, 32'h0, 1'b1};
    vecs[6]  = '{1'b0, 32'h8000_0000, 32'h0,         3'b010, 32'hDE11_2233, 1'b0};
    vecs[7]  = '{1'b0, 32'h8000_0003, 32'h0,         3'b001, 32'h0, 1'b1};
    vecs[8]  = '{1'b1, 32'h8000_0000, 32'h0,         3'b101, 32'h0, 1'b1};
    vecs[9]  = '{1'b0, 32'h8000_0000, 32'h0,         3'b010, 32'hDE11_2233, 1'b0};
    vecs[10] = '{1'b0, 32'h8000_1000, 32'h0,         3'b010, 32'h0, 1'b1};
    vecs[11] = '{1'b1, 32'h8000_1000, 32'h5A5A_5A5A, 3'b010, 32'h0, 1'b1};
    vecs[12] = '{1'b0, 32'h8000_0000, 32'h0,         3'b010, 32'hDE11_2233, 1'b0};
    vecs[13] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         3'b010, 32'h0, 1'b1};
    vecs[14] = '{1'b1, 32'h8000_0FFC, 32'h1234_5678, 3'b010, 32'h0, 1'b0};
    vecs[15] = '{1'b0, 32'h8000_0FFC, 32'h0,         3'b010, 32'h1234_5678, 1'b0};
    vecs[16] = '{1'b0, 32'h8000_0FFF, 32'h0,         3'b000, 32'h1234_5678, 1'b0};
    vecs[17] = '{1'b1, 32'h8000_0FFE, 32'hFFFF_ABCD, 3'b001, 32'h0, 1'b0};
    vecs[18] = '{1'b0, 32'h8000_0FFC, 32'h0,         3'b010, 32'hABCD_5678, 1'b0};
    vecs[19] = '{1'b0, 32'h8000_0000, 32'h0,         3'b101, 32'hDE11_2233, 1'b0};
    vecs[20] = '{1'b1, 32'h8000_0FFD, 32'hFFFF_FF77, 3'b000, 32'h0, 1'b0};
    vecs[21] = '{1'b0, 32'h8000_0FFC, 32'h0,         3'b010, 32'hABCD_7778, 1'b0};

    rst_n = '0; en = '0; we = '0; rready = '1;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; wdata[k] = '0; wmask[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset%0d ready", k), 32'(ready[k]), 32'd1);
      check($sformatf("reset%0d rvalid", k), 32'(rvalid[k]), 32'd0);
      check($sformatf("reset%0d rdata", k), rdata[k], 32'd0);
      check($sformatf("reset%0d err", k), 32'(err[k]), 32'd0);
    end
    rst_n = '1;

    // Directed vectors at LATENCY=1.
    for (int i = 0; i < 22; i++) begin
      txn(0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].m, rd, er, lat, rl);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_er));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
      check($sformatf("vec%0d ready_low", i), 32'(rl), 32'd1);
    end

    // LATENCY=4 with response backpressure and a request held during the busy window.
    txn(1, 1'b1, 32'h8000_0010, 32'hCAFE_F00D, 3'b010, rd, er, lat, rl);
    check("l4 store latency", 32'(lat), 32'd4);
    check("l4 store ready_low", 32'(rl), 32'd4);
    check("l4 store err", 32'(er), 32'd0);
    @(negedge clk);
    en[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h8000_0010; wmask[1] = 3'b010; rready[1] = 1'b0;
    @(posedge clk);
    #1 we[1] = 1'b1; wdata[1] = 32'h1111_2222;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      check($sformatf("bp cyc%0d ready", n), 32'(ready[1]), 32'd0);
      check($sformatf("bp cyc%0d rvalid", n), 32'(rvalid[1]), (n >= 4) ? 32'd1 : 32'd0);
      if (n >= 4) check($sformatf("bp cyc%0d rdata", n), rdata[1], 32'hCAFE_F00D);
    end
    rready[1] = 1'b1;
    @(negedge clk);
    check("bp after retire ready", 32'(ready[1]), 32'd1);
    check("bp after retire rvalid", 32'(rvalid[1]), 32'd0);
    check("bp after retire rdata", rdata[1], 32'hCAFE_F00D);
    @(posedge clk);
    #1 en[1] = 1'b0;
    wait_resp(1, rd, er, lat, rl);
    check("held store latency", 32'(lat), 32'd4);
    check("held store err", 32'(er), 32'd0);
    check("held store rdata", rd, 32'd0);
    txn(1, 1'b0, 32'h8000_0010, 32'h0, 3'b010, rd, er, lat, rl);
    check("held store readback", rd, 32'h1111_2222);

    // LATENCY=8, reset in the middle of WAIT.
    txn(2, 1'b1, 32'h8000_0020, 32'h0BAD_F00D, 3'b010, rd, er, lat, rl);
    check("l8 store latency", 32'(lat), 32'd8);
    @(negedge clk);
    en[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h8000_0020; wmask[2] = 3'b010;
    @(posedge clk);
    #1 en[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n[2] = 1'b0;
    #1;
    check("midrst ready", 32'(ready[2]), 32'd1);
    check("midrst rvalid", 32'(rvalid[2]), 32'd0);
    check("midrst rdata", rdata[2], 32'd0);
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    bad_cycles = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (rvalid[2] !== 1'b0 || ready[2] !== 1'b1) bad_cycles++;
    end
    check("midrst no response", 32'(bad_cycles), 32'd0);
    txn(2, 1'b0, 32'h8000_0020, 32'h0, 3'b010, rd, er, lat, rl);
    check("post-rst load rdata", rd, 32'h0BAD_F00D);
    check("post-rst load latency", 32'(lat), 32'd8);

    // Back-to-back store/load pairs at random aligned addresses.
    for (int i = 0; i < 16; i++) begin
      a = 32'h8000_0000 + 32'($urandom_range(0, 1023)) * 32'd4;
      d = $urandom;
      txn(0, 1'b1, a, d, 3'b010, rd, er, lat, rl);
      check($sformatf("b2b%0d store err", i), 32'(er), 32'd0);
      txn(0, 1'b0, a, 32'h0, 3'b010, rd, er, lat, rl);
      check($sformatf("b2b%0d load @%h", i, a), rd, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24090003_dmem_resp.md
# ysyx_24090003_dmem_resp

Data-memory responder for the `ysyx_24090003` core: the target end of the CPU's `o_mem_*` load/store interface. It accepts one request at a time with a valid/ready handshake and holds a word-organised store with per-store byte lanes. It returns a response after a configurable latency, so the core can be tested against non-ideal memory. It sits beside the CPU top in the simulation/SoC wrapper, in place of the DPI memory model.

## Interface
- `DEPTH_WORDS`, 1024: storage size in 32-bit words (power of two).
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0.
- `LATENCY`, 1: number of cycles from the accepting edge to response-valid; legal range 1..15; an elaboration error for values outside that range.
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_mem_en` in 1: request valid.
- `i_mem_we` in 1: 1 = store, 0 = load.
- `i_mem_addr` in 32: byte address.
- `i_mem_wdata` in 32: store data, right-aligned; the block shifts it into its byte lane.
- `i_mem_wmask` in 3: store width code, matching store funct3: 3'b000 byte, 3'b001 half, 3'b010 word.
- `o_mem_ready` out 1: the block can accept a request this cycle.
- `o_mem_rvalid` out 1: a response is valid.
- `i_mem_rready` in 1: the initiator accepts the response.
- `o_mem_rdata` out 32: the full aligned word for loads; 0 for stores and errors.
- `o_mem_err` out 1: the response is an error; qualified by `o_mem_rvalid`.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - `o_mem_ready`=1.
  - A request is accepted on an edge where `i_mem_en && o_mem_ready`. Address, we, wdata and wmask are latched.
  - The next state is RESP if `LATENCY`==1. Otherwise it is WAIT, with the counter set to `LATENCY`-2.
- **WAIT:**
  - `o_mem_ready`=0.
  - The counter decrements each cycle; at 0 the FSM moves to RESP.
- **RESP:**
  - `o_mem_rvalid`=1, and `o_mem_rdata`/`o_mem_err` are held stable.
  - On an edge with `i_mem_rready`=1 the FSM returns to IDLE. Otherwise it stays in RESP.
- **Error detection** (evaluated at accept):
  - The request is an error if the word index `(addr-BASE_ADDR)>>2` is ≥ `DEPTH_WORDS`.
  - It is also an error if addr < `BASE_ADDR`.
  - A half access with addr[0]=1 is an error.
  - A word access with addr[1:0]≠0 is an error.
  - A store with wmask ∉ {000,001,010} is an error.
  - Loads ignore wmask.
  - An error performs no write and returns `o_mem_err`=1, `o_mem_rdata`=0.
- **Store commit:**
  - The array is written on the accepting edge.
  - Byte: lane addr[1:0] receives wdata[7:0].
  - Half: lanes {addr[1],0}+1..0 receive wdata[15:0].
  - Word: all lanes are written.
  - Other lanes are unchanged.
- **Load data:**
  - The aligned word is read on the accepting edge and registered into `o_mem_rdata`.
  - The LSU performs lane selection and sign extension.
- **Response:** every accepted request, load or store, produces exactly one response.
- **Reset state:**
  - Reset forces IDLE, `o_mem_ready`=1, `o_mem_rvalid`=0, `o_mem_rdata`=0, `o_mem_err`=0, counter=0.
  - Reset asserted mid-transaction discards it with no response. A store already accepted stays committed.
  - Array contents are not reset.

## Timing
- Accept at edge t: `o_mem_rvalid` is high in the cycle after edge t+`LATENCY`-1.
- `o_mem_ready` falls in the cycle after edge t.
- It returns high in the cycle after the edge that retires the response (`rvalid && rready`).
- At most one outstanding request.
- Throughput is one transaction per `LATENCY`+1 cycles with `i_mem_rready` tied high.
- `o_mem_rdata` and `o_mem_err` change only on entry to RESP or on reset.
- A request asserted while `o_mem_ready`=0 is ignored. The initiator holds it until accepted.
- A load accepted after a store to the same word returns the stored value.

## Structure
- Add to `ysyx_24090003_define.v`:
  - width codes `MEM_W_BYTE`/`MEM_W_HALF`/`MEM_W_WORD`.
  - FSM state encodings `DMEM_IDLE`/`DMEM_WAIT`/`DMEM_RESP`.
  - counter width 4.
- Sub-module `ysyx_24090003_dmem_array`:
  - a `DEPTH_WORDS`×32 array with 4-bit byte-enable synchronous write and synchronous read.
  - The FSM, error check and lane shifting stay in the top.

## Test plan
- **Reset:** `LATENCY`=1; store word 0xDEADBEEF at 0x8000_0000, then load it.
  - rvalid is high one cycle after each accept.
  - The load returns 0xDEADBEEF with err=0.
  - ready is low for exactly 1 cycle per transaction with rready=1.
- **Byte/half lanes:** after the word above, store byte 0x11 at 0x8000_0002, then half 0x2233 at 0x8000_0000.
  - A load returns 0xDE112233.
- **Errors:** each of the following returns err=1, rdata=0, and a reload of the word is unchanged.
  - Word store at 0x8000_0001.
  - Half load at 0x8000_0003.
  - Store with wmask=3'b101.
  - Load at 0x8000_1000 with DEPTH_WORDS=1024.
- **Latency and backpressure:** `LATENCY`=4, rready held low for 3 cycles after rvalid rises.
  - rvalid appears in the cycle after edge t+3.
  - rdata is stable while held.
  - ready stays 0 until the retire edge.
  - A request presented meanwhile is accepted only after retire.
- **Reset mid-WAIT:** `LATENCY`=8, deassert i_rst_n 3 cycles after a load accept.
  - rvalid stays 0, ready=1 after release.
  - The next load completes normally.
- **Back-to-back:** with rready=1 and LATENCY=1, 16 alternating store/load pairs to random aligned addresses each read back the stored data.
